// File: rtl/scan_ram.sv
// scan_ram: word-addressed RAM with a host write/read port and a playback
// engine that streams a programmable address window over valid/ready.
// The window may wrap past the top of memory and optionally repeats until
// stopped. Memory contents survive reset; only control state is cleared.
module scan_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              play_start_i,
  input  logic              play_stop_i,
  input  logic [ADDR_W-1:0] play_base_i,
  input  logic [ADDR_W:0]   play_len_i,
  input  logic              play_loop_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  // DEPTH at address-plus-one width so range checks compare like widths.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              loop_q, loop_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  logic              wr_in_range;
  logic              rd_in_range;
  logic [ADDR_W-1:0] base_start;
  logic [ADDR_W:0]   len_start;
  logic [ADDR_W-1:0] ptr_next;

  assign wr_in_range = ({1'b0, wr_addr_i} < DEPTH_C);
  assign rd_in_range = ({1'b0, rd_addr_i} < DEPTH_C);

  // Out-of-range window base restarts at 0; over-long windows cover all of memory.
  assign base_start = ({1'b0, play_base_i} >= DEPTH_C) ? '0 : play_base_i;
  assign len_start  = (play_len_i > DEPTH_C) ? DEPTH_C : play_len_i;
  assign ptr_next   = ({1'b0, ptr_q} == (DEPTH_C - 1'b1)) ? '0 : ptr_q + 1'b1;

  // Host writes; addresses beyond DEPTH are dropped.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && wr_in_range) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Host read port: one-cycle latency, read-before-write on address collision.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_data_q <= rd_in_range ? mem_q[rd_addr_i] : '0;
      end
    end
  end

  // Playback next-state: stop beats fetch and start; a fetch happens whenever
  // the output slot is empty or being drained this cycle.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    loop_d      = loop_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (play_start_i && !play_stop_i) begin
          if (play_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            base_d  = base_start;
            len_d   = len_start;
            loop_d  = play_loop_i;
            ptr_d   = base_start;
            count_d = '0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (play_stop_i) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end else if (!out_valid_q || out_ready_i) begin
          out_data_d  = mem_q[ptr_q];
          out_valid_d = 1'b1;
          ptr_d       = ptr_next;
          count_d     = count_q + 1'b1;
          if (count_q == (len_q - 1'b1)) begin
            if (loop_q) begin
              ptr_d   = base_q;
              count_d = '0;
            end else begin
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (play_stop_i || (out_valid_q && out_ready_i)) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Playback state register; reset clears control and outputs, never memory.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      loop_q      <= 1'b0;
      ptr_q       <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      loop_q      <= loop_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;

endmodule
